// File: rtl/wca_dsp_pkg.sv
// Shared types and constants for the DSP counter controller.
package wca_dsp_pkg;

   localparam int CNT_MAXBITS = 24;

   typedef logic [CNT_MAXBITS:0] count_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/wca_cnt_term_detect.sv
// Terminal-count detector: compares the count the counter will show next cycle
// against the terminal value, so the flag is registered yet aligned with cnt_q.
module wca_cnt_term_detect
   import wca_dsp_pkg::*;
#(
   parameter int MAXBITS = CNT_MAXBITS
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             arm,
   input  logic             kill,
   input  logic [MAXBITS:0] nxt_cnt,
   input  logic [MAXBITS:0] tv,
   output logic             hit,
   output logic             term,
   output logic             tick
);

   assign hit = arm && (nxt_cnt == tv);

   // A terminal pre-empted by stop/start must not produce a tick.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         term <= 1'b0;
         tick <= 1'b0;
      end else begin
         term <= hit;
         tick <= term && !kill;
      end
   end

endmodule

// File: rtl/wca_dsp_counter_ctrl.sv
// Sequencer for the shared loadable up/down DSP counter (load/dir/data, tick, done).
// Optional capture/snapshot port enabled by defining WCA_CNTCTRL_SNAPSHOT_EN.
module wca_dsp_counter_ctrl
   import wca_dsp_pkg::*;
#(
   parameter int MAXBITS = CNT_MAXBITS
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             periodic,
   input  logic             dir_up,
   input  logic [MAXBITS:0] period,
   input  logic [MAXBITS:0] cnt_q,
`ifdef WCA_CNTCTRL_SNAPSHOT_EN
   input  logic             capture,
`endif
   output logic             cnt_load,
   output logic             cnt_up,
   output logic [MAXBITS:0] cnt_data,
   output logic             busy,
   output logic             tick,
   output logic             done,
   output logic [MAXBITS:0] snap
);

   localparam logic [MAXBITS:0] ONE = 1;

   state_t           state, state_nxt;
   logic             dir_r, dir_d;
   logic [MAXBITS:0] per_r, per_d;
   logic             reload_r, reload_d;
   logic             load_d, up_d, busy_d, done_d;
   logic [MAXBITS:0] data_d;
   logic [MAXBITS:0] nxt_cnt, tv;
   logic             hit, term;

   // Outputs are registered, so decisions are taken on the count the counter will show next.
   assign nxt_cnt = cnt_load ? cnt_data : (cnt_up ? cnt_q + ONE : cnt_q - ONE);
   assign tv      = dir_r ? per_r : '0;

   wca_cnt_term_detect #(.MAXBITS(MAXBITS)) u_term (
      .clock   (clock),
      .reset   (reset),
      .arm     (state_nxt == RUN),
      .kill    (stop || start),
      .nxt_cnt (nxt_cnt),
      .tv      (tv),
      .hit     (hit),
      .term    (term),
      .tick    (tick)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (stop)       state_nxt = IDLE;
      else if (start) state_nxt = LOAD;
      else begin
         case (state)
            IDLE:    state_nxt = IDLE;
            LOAD:    state_nxt = RUN;
            RUN: begin
               if (term && !reload_r) state_nxt = DONE;
               else if (pause)        state_nxt = PAUSE;
               else                   state_nxt = RUN;
            end
            PAUSE:   state_nxt = pause ? PAUSE : RUN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      load_d   = 1'b1;
      data_d   = cnt_data;
      up_d     = dir_r;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      dir_d    = dir_r;
      per_d    = per_r;
      reload_d = 1'b0;
      case (state_nxt)
         IDLE: begin
            data_d = '0;
            up_d   = 1'b0;
         end
         LOAD: begin
            dir_d  = dir_up;
            per_d  = period;
            up_d   = dir_up;
            busy_d = 1'b1;
            data_d = dir_up ? '0 : period;
         end
         RUN: begin
            busy_d = 1'b1;
            if (hit) begin
               reload_d = periodic;
               if (periodic) begin
                  per_d  = period;
                  data_d = dir_r ? '0 : period;
               end else begin
                  data_d = tv;
               end
            end else begin
               load_d = 1'b0;
            end
         end
         // The counter has no enable, so a pause reloads the value it would have shown.
         PAUSE: begin
            busy_d = 1'b1;
            data_d = nxt_cnt;
         end
         DONE: begin
            done_d = 1'b1;
            data_d = tv;
         end
         default: data_d = '0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_load <= 1'b1;
         cnt_data <= '0;
         cnt_up   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         dir_r    <= 1'b0;
         per_r    <= '0;
         reload_r <= 1'b0;
      end else begin
         cnt_load <= load_d;
         cnt_data <= data_d;
         cnt_up   <= up_d;
         busy     <= busy_d;
         done     <= done_d;
         dir_r    <= dir_d;
         per_r    <= per_d;
         reload_r <= reload_d;
      end
   end

`ifdef WCA_CNTCTRL_SNAPSHOT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)              snap <= '0;
      else if (capture && busy) snap <= cnt_q;
   end
`else
   assign snap = '0;
`endif

endmodule

// File: tb/tb_wca_dsp_counter_ctrl.sv
// Scoreboard bench for wca_dsp_counter_ctrl with a behavioural model of the shared counter.
module tb_wca_dsp_counter_ctrl;
   import wca_dsp_pkg::*;

   localparam int P_Q = 0, P_BUSY = 1, P_TICK = 2, P_DONE = 3;
   localparam int P_LOAD = 4, P_DATA = 5, P_SNAP = 6, P_UP = 7;

   logic   clock = 1'b0;
   logic   reset = 1'b0;
   logic   start = 1'b0, stop = 1'b0, pause = 1'b0, periodic = 1'b0, dir_up = 1'b0;
   count_t period = '0;
   count_t cnt_q = '0;
   logic   cnt_load, cnt_up, busy, tick, done;
   count_t cnt_data, snap;
`ifdef WCA_CNTCTRL_SNAPSHOT_EN
   logic   capture = 1'b0;
`endif

   wca_dsp_counter_ctrl dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .stop     (stop),
      .pause    (pause),
      .periodic (periodic),
      .dir_up   (dir_up),
      .period   (period),
      .cnt_q    (cnt_q),
`ifdef WCA_CNTCTRL_SNAPSHOT_EN
      .capture  (capture),
`endif
      .cnt_load (cnt_load),
      .cnt_up   (cnt_up),
      .cnt_data (cnt_data),
      .busy     (busy),
      .tick     (tick),
      .done     (done),
      .snap     (snap)
   );

   always #5 clock = ~clock;

   // Shared counter: load has priority, otherwise counts every clock.
   always @(posedge clock) begin
      if (cnt_load)    cnt_q <= cnt_data;
      else if (cnt_up) cnt_q <= cnt_q + 1'b1;
      else             cnt_q <= cnt_q - 1'b1;
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct { int cyc; bit t; bit d; } ev_t;
   typedef struct { int cyc; int sel; logic [31:0] val; string nm; } pr_t;
   ev_t evq[$];
   pr_t prq[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   task automatic ev(input int c, input bit t, input bit d);
      evq.push_back('{c, t, d});
   endtask

   task automatic pr(input int c, input int sel, input int unsigned v, input string nm);
      prq.push_back('{c, sel, 32'(v), nm});
   endtask

   function automatic logic [31:0] obs(input int sel);
      case (sel)
         P_Q:     return 32'(cnt_q);
         P_BUSY:  return 32'(busy);
         P_TICK:  return 32'(tick);
         P_DONE:  return 32'(done);
         P_LOAD:  return 32'(cnt_load);
         P_DATA:  return 32'(cnt_data);
         P_SNAP:  return 32'(snap);
         default: return 32'(cnt_up);
      endcase
   endfunction

   // Monitor: strobes are matched against the event queue, probes against their cycle.
   always @(negedge clock) begin
      ev_t e;
      pr_t p;
      if (tick || done) begin
         n_cmp++;
         if (evq.size() == 0) begin
            n_bad++;
            $display("FAIL strobe: got tick=%0b done=%0b at cycle %0d, required no strobe",
                     tick, done, cyc);
         end else begin
            e = evq.pop_front();
            if (e.cyc != cyc || e.t != tick || e.d != done) begin
               n_bad++;
               $display("FAIL strobe: got tick=%0b done=%0b at cycle %0d, required tick=%0b done=%0b at cycle %0d",
                        tick, done, cyc, e.t, e.d, e.cyc);
            end
         end
      end
      for (int i = prq.size() - 1; i >= 0; i--) begin
         if (prq[i].cyc <= cyc) begin
            p = prq[i];
            prq.delete(i);
            n_cmp++;
            if (p.cyc != cyc || obs(p.sel) !== p.val) begin
               n_bad++;
               $display("FAIL %s: got %0d at cycle %0d, required %0d at cycle %0d",
                        p.nm, obs(p.sel), cyc, p.val, p.cyc);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic go(input bit d, input int unsigned per, input bit prd, output int b);
      dir_up   = d;
      period   = count_t'(per);
      periodic = prd;
      start    = 1'b1;
      b        = cyc;
      step(1);
      start    = 1'b0;
   endtask

   initial begin
      int b;
      step(1);
      pr(cyc, P_LOAD, 1, "rst cnt_load");
      pr(cyc, P_DATA, 0, "rst cnt_data");
      pr(cyc, P_UP,   0, "rst cnt_up");
      pr(cyc, P_BUSY, 0, "rst busy");
      pr(cyc, P_TICK, 0, "rst tick");
      pr(cyc, P_DONE, 0, "rst done");
      pr(cyc, P_SNAP, 0, "rst snap");
      step(2);
      reset = 1'b1;
      step(2);

      // Down, periodic, period 4: tick every 5 cycles.
      go(1'b0, 4, 1'b1, b);
      pr(b+1, P_BUSY, 1, "A busy load");
      pr(b+1, P_LOAD, 1, "A load strobe");
      pr(b+1, P_DATA, 4, "A load data");
      pr(b+2, P_Q, 4, "A q first");
      pr(b+3, P_Q, 3, "A q second");
      pr(b+6, P_Q, 0, "A q terminal");
      pr(b+7, P_Q, 4, "A q reload");
      pr(b+11, P_Q, 0, "A q terminal2");
      pr(b+12, P_Q, 4, "A q reload2");
      ev(b+7, 1, 0);
      ev(b+12, 1, 0);
      ev(b+17, 1, 0);
      step(18);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      pr(cyc, P_BUSY, 0, "A busy after stop");
      step(3);

      // Up, one-shot, period 3: tick and done after the terminal cycle.
      go(1'b1, 3, 1'b0, b);
      pr(b+1, P_UP, 1, "B cnt_up");
      pr(b+2, P_Q, 0, "B q first");
      pr(b+5, P_Q, 3, "B q terminal");
      pr(b+6, P_Q, 3, "B q held done");
      pr(b+6, P_BUSY, 0, "B busy done");
      pr(b+7, P_Q, 3, "B q held idle");
      pr(b+7, P_DATA, 0, "B park data");
      pr(b+8, P_Q, 0, "B q parked");
      ev(b+6, 1, 1);
      step(9);

      // Pause seen while q=7 freezes the count at 6 for four extra cycles.
      go(1'b0, 10, 1'b1, b);
      pr(b+5, P_Q, 7, "C q before pause");
      pr(b+6, P_Q, 6, "C q frozen");
      pr(b+7, P_BUSY, 1, "C busy pause");
      pr(b+8, P_Q, 6, "C q frozen2");
      pr(b+10, P_Q, 6, "C q resume");
      pr(b+11, P_Q, 5, "C q counting");
      pr(b+16, P_Q, 0, "C q terminal");
      pr(b+17, P_Q, 10, "C q reload");
      ev(b+17, 1, 0);
      step(4);
      pause = 1'b1;
      step(4);
      pause = 1'b0;
      step(9);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      step(2);

      // Stop and start together in RUN: stop wins, no tick.
      go(1'b0, 4, 1'b1, b);
      step(3);
      stop  = 1'b1;
      start = 1'b1;
      step(1);
      stop  = 1'b0;
      start = 1'b0;
      pr(b+5, P_BUSY, 0, "D busy");
      pr(b+5, P_LOAD, 1, "D park load");
      pr(b+6, P_Q, 0, "D q parked");
      step(8);

      // Start in RUN at q=2 restarts from the period.
      go(1'b0, 4, 1'b1, b);
      step(3);
      pr(cyc, P_Q, 2, "E q at restart");
      start = 1'b1;
      step(1);
      start = 1'b0;
      pr(b+5, P_BUSY, 1, "E busy reload");
      pr(b+5, P_LOAD, 1, "E load strobe");
      pr(b+5, P_DATA, 4, "E load data");
      pr(b+6, P_Q, 4, "E q restart");
      pr(b+10, P_Q, 0, "E q terminal");
      ev(b+11, 1, 0);
      step(6);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      step(2);

      // Period 0, down: tick every cycle, then period 7 takes effect at the next reload.
      go(1'b0, 0, 1'b1, b);
      pr(b+2, P_Q, 0, "F q zero");
      ev(b+3, 1, 0);
      ev(b+4, 1, 0);
      step(4);
      period = count_t'(7);
      ev(b+5, 1, 0);
      ev(b+6, 1, 0);
      ev(b+7, 1, 0);
      ev(b+15, 1, 0);
      ev(b+23, 1, 0);
      pr(b+6, P_Q, 0, "F q last zero");
      pr(b+7, P_Q, 7, "F q new period");
      pr(b+8, P_Q, 6, "F q counting");
      pr(b+14, P_Q, 0, "F q terminal");
      pr(b+15, P_Q, 7, "F q reload");
      step(19);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      step(2);

      // Period 0, up: same cadence; stop on a terminal cycle suppresses its tick.
      go(1'b1, 0, 1'b1, b);
      ev(b+3, 1, 0);
      ev(b+4, 1, 0);
      ev(b+5, 1, 0);
      step(4);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      pr(b+6, P_BUSY, 0, "F2 busy");
      step(3);

      // Snapshot of the running count; capture in IDLE is ignored.
      go(1'b0, 8, 1'b1, b);
      step(4);
      pr(cyc, P_Q, 5, "G q at capture");
`ifdef WCA_CNTCTRL_SNAPSHOT_EN
      capture = 1'b1;
      step(1);
      capture = 1'b0;
      pr(b+6, P_SNAP, 5, "G snap");
      pr(b+9, P_SNAP, 5, "G snap hold");
      step(3);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      capture = 1'b1;
      step(1);
      capture = 1'b0;
      pr(b+11, P_SNAP, 5, "G snap idle capture");
`else
      step(1);
      pr(b+6, P_SNAP, 0, "G snap tied");
      step(3);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      step(1);
`endif
      step(2);

      // Async reset between edges on the cycle that would tick.
      go(1'b0, 4, 1'b1, b);
      step(6);
      pr(b+7, P_TICK, 0, "H tick in reset");
      pr(b+7, P_BUSY, 0, "H busy in reset");
      pr(b+7, P_LOAD, 1, "H cnt_load in reset");
      pr(b+7, P_DATA, 0, "H cnt_data in reset");
      pr(b+7, P_DONE, 0, "H done in reset");
      pr(b+7, P_UP, 0, "H cnt_up in reset");
      #1 reset = 1'b0;
      step(2);
      reset = 1'b1;
      step(1);
      pr(cyc, P_BUSY, 0, "H busy after reset");
      pr(cyc + 2, P_Q, 0, "H q parked");
      step(4);

      while (evq.size() > 0) begin
         ev_t e;
         e = evq.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL strobe: got none, required tick=%0b done=%0b at cycle %0d", e.t, e.d, e.cyc);
      end
      while (prq.size() > 0) begin
         pr_t p;
         p = prq.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got no sample, required %0d at cycle %0d", p.nm, p.val, p.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
